i2s_output: RTL and testbench

- I2S transmitter driving an external stereo audio DAC.
- Counterpart to the transceiver's external-ADC I2S receive path (bclk_in/lrclk_in/dout_in). This block is master and generates bit clock, word clock and serial data.
- Takes 32-bit stereo words from the CPU/audio stream over the codebase stb/ack handshake, holds one word in a single-entry buffer, and serialises one stereo frame of 64 bit clocks per sample.
- Sits in the clk_50 domain alongside serial_output/serial_input.

---
 rtl/i2s_output.sv | 132 +++++++++++++
 tb/tb_i2s_output.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_output.sv
// I2S master transmitter for an external stereo DAC.
// Generates bclk/lrclk, serialises one 64-bclk stereo frame per sample.
//
// Ports:
//   clk            system clock (clk_50)
//   rst_n          asynchronous active-low reset
//   audio_in       {left[31:16], right[15:0]} two's-complement samples
//   audio_in_stb   word valid from the source
//   audio_in_ack   holding buffer can take a word; transfer on stb && ack
//   bclk_out       bit clock, f_clk / (2*BCLK_DIV)
//   lrclk_out      word select, 0 = left, 1 = right
//   dout_out       serial data, MSB first, one bclk after lrclk changes
//   frame_stb_out  one-clk pulse at each frame load
//   underrun_out   one-clk pulse when a frame loads from an empty buffer
module i2s_output #(
    parameter int BCLK_DIV     = 8,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] audio_in,
    input  logic        audio_in_stb,
    output logic        audio_in_ack,
    output logic        bclk_out,
    output logic        lrclk_out,
    output logic        dout_out,
    output logic        frame_stb_out,
    output logic        underrun_out
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);
    localparam logic [5:0] SW       = 6'(SAMPLE_WIDTH);

    logic [7:0]  div_cnt_q;
    logic        bclk_q;
    logic [5:0]  bit_cnt_q;
    logic        lrclk_q;
    logic        dout_q;
    logic [31:0] hold_q;
    logic        hold_full_q;
    logic [31:0] frame_q;
    logic        frame_stb_q;
    logic        underrun_q;

    logic        tick;
    logic        fall;
    logic        load;
    logic        accept;
    logic [5:0]  bit_d;
    logic        dout_d;
    logic        hold_full_d;
    logic [31:0] left_ext;
    logic [31:0] right_ext;
    logic [4:0]  idx;

    assign tick  = (div_cnt_q == DIV_LAST);
    assign fall  = tick & bclk_q;
    assign bit_d = bit_cnt_q + 6'd1;
    assign load  = fall & (bit_d == 6'd0);

    // The buffer is drained by a load in this very cycle, so a word
    // offered now can take its place without a bubble.
    assign audio_in_ack = ~hold_full_q | load;
    assign accept       = audio_in_stb & audio_in_ack;

    // One-bit I2S delay: slot n carries sample bit [SW-n] of its half.
    always_comb begin
        left_ext  = {16'b0, frame_q[31:16]};
        right_ext = {16'b0, frame_q[15:0]};
        dout_d    = 1'b0;
        idx       = 5'd0;
        if (bit_d >= 6'd1 && bit_d <= SW) begin
            idx    = 5'(SW - bit_d);
            dout_d = left_ext[idx];
        end else if (bit_d >= 6'd33 && bit_d <= 6'd32 + SW) begin
            idx    = 5'(SW - (bit_d - 6'd32));
            dout_d = right_ext[idx];
        end
    end

    always_comb begin
        hold_full_d = hold_full_q;
        if (accept) begin
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= 8'd0;
            bclk_q      <= 1'b0;
            bit_cnt_q   <= 6'd63;
            lrclk_q     <= 1'b1;
            dout_q      <= 1'b0;
            hold_q      <= 32'd0;
            hold_full_q <= 1'b0;
            frame_q     <= 32'd0;
            frame_stb_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            if (tick) begin
                div_cnt_q <= 8'd0;
                bclk_q    <= ~bclk_q;
            end else begin
                div_cnt_q <= div_cnt_q + 8'd1;
            end
            if (fall) begin
                bit_cnt_q <= bit_d;
                lrclk_q   <= bit_d[5];
                dout_q    <= dout_d;
            end
            frame_stb_q <= load;
            underrun_q  <= load & ~hold_full_q;
            if (load) begin
                frame_q <= hold_full_q ? hold_q : 32'd0;
            end
            if (accept) begin
                hold_q <= audio_in;
            end
            hold_full_q <= hold_full_d;
        end
    end

    assign bclk_out      = bclk_q;
    assign lrclk_out     = lrclk_q;
    assign dout_out      = dout_q;
    assign frame_stb_out = frame_stb_q;
    assign underrun_out  = underrun_q;

endmodule

// File: tb/tb_i2s_output.sv
// Self-checking bench for i2s_output.
// Frames are decoded from dout at bclk rises and compared to a word queue.
`timescale 1ns/1ps
module tb_i2s_output;

    localparam int DIV = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] audio_in = 32'd0;
    logic        audio_in_stb = 1'b0;
    logic        audio_in_ack;
    logic        bclk_out;
    logic        lrclk_out;
    logic        dout_out;
    logic        frame_stb_out;
    logic        underrun_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] w;
        int          t;
    } item_t;

    item_t q[$];

    i2s_output #(.BCLK_DIV(DIV), .SAMPLE_WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .audio_in      (audio_in),
        .audio_in_stb  (audio_in_stb),
        .audio_in_ack  (audio_in_ack),
        .bclk_out      (bclk_out),
        .lrclk_out     (lrclk_out),
        .dout_out      (dout_out),
        .frame_stb_out (frame_stb_out),
        .underrun_out  (underrun_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Release happens on a negedge; the next posedge is clk 1.
    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        audio_in_stb = 1'b0;
        q.delete();
        step(3);
        rst_n = 1'b1;
    endtask

    task automatic wait_frame(output bit ok, output bit und);
        ok = 1'b0;
        und = 1'b0;
        for (int i = 0; i < 4 * 64 * DIV; i++) begin
            @(negedge clk);
            if (frame_stb_out) begin
                ok = 1'b1;
                und = underrun_out;
                break;
            end
        end
    endtask

    // Sample 64 bclk rises following a frame load (slots 0..63).
    task automatic collect(output logic [31:0] w, output int other,
                           output int lrerr, output bit ok);
        w = 32'd0;
        other = 0;
        lrerr = 0;
        ok = 1'b1;
        for (int s = 0; s < 64; s++) begin
            for (int i = 0; i < 4 * DIV && bclk_out; i++) @(negedge clk);
            for (int i = 0; i < 4 * DIV && !bclk_out; i++) @(negedge clk);
            if (!bclk_out) ok = 1'b0;
            if (s >= 1 && s <= 16) w[32 - s] = dout_out;
            else if (s >= 33 && s <= 48) w[48 - s] = dout_out;
            else if (dout_out !== 1'b0) other++;
            if (lrclk_out !== (s >= 32)) lrerr++;
        end
    endtask

    task automatic test_reset;
        int rise, rise2, fall, k;
        logic p, lr, stbf;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bclk_out, lrclk_out, dout_out, audio_in_ack,
             frame_stb_out, underrun_out} !== 6'b010100) begin
            n_bad++;
            $display("FAIL reset_vals got %b want 010100",
                     {bclk_out, lrclk_out, dout_out, audio_in_ack,
                      frame_stb_out, underrun_out});
        end
        step(2);
        rst_n = 1'b1;
        rise = -1; rise2 = -1; fall = -1;
        p = 1'b0; lr = 1'bx; stbf = 1'bx;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bclk_out && !p) begin
                if (rise < 0) rise = k;
                else if (rise2 < 0) rise2 = k;
            end
            if (!bclk_out && p && fall < 0) begin
                fall = k;
                lr = lrclk_out;
                stbf = frame_stb_out;
            end
            p = bclk_out;
        end
        n_cmp++;
        if (rise != DIV) begin
            n_bad++;
            $display("FAIL first_rise got %0d want %0d", rise, DIV);
        end
        n_cmp++;
        if (fall != 2 * DIV) begin
            n_bad++;
            $display("FAIL first_fall got %0d want %0d", fall, 2 * DIV);
        end
        n_cmp++;
        if (lr !== 1'b0 || stbf !== 1'b1) begin
            n_bad++;
            $display("FAIL fall_lr_stb got %b%b want 01", lr, stbf);
        end
        n_cmp++;
        if (rise2 - rise != 2 * DIV) begin
            n_bad++;
            $display("FAIL bclk_period got %0d want %0d",
                     rise2 - rise, 2 * DIV);
        end
    endtask

    task automatic test_single;
        logic [31:0] w;
        int oth, lre;
        bit ok, und;
        do_reset();
        audio_in = 32'hA5A5_3C3C;
        audio_in_stb = 1'b1;
        n_cmp++;
        if (audio_in_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL single_ack_empty got %b want 1", audio_in_ack);
        end
        step(1);
        audio_in_stb = 1'b0;
        n_cmp++;
        if (audio_in_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL single_ack_full got %b want 0", audio_in_ack);
        end
        wait_frame(ok, und);
        n_cmp++;
        if (!ok || und !== 1'b0) begin
            n_bad++;
            $display("FAIL single_load got ok=%0d und=%0d want 1 0", ok, und);
        end
        collect(w, oth, lre, ok);
        n_cmp++;
        if (!ok || w !== 32'hA5A5_3C3C || oth != 0 || lre != 0) begin
            n_bad++;
            $display("FAIL single_frame got %h oth=%0d lr=%0d want a5a53c3c 0 0",
                     w, oth, lre);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w;
        int oth, lre, k;
        bit ok, und;
        do_reset();
        audio_in = 32'h1111_2222;
        audio_in_stb = 1'b1;
        step(1);
        n_cmp++;
        if (audio_in_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_ack_drop got %b want 0", audio_in_ack);
        end
        audio_in = 32'h3333_4444;
        k = 0;
        for (int i = 0; i < 3000; i++) begin
            if (audio_in_ack) break;
            step(1);
            k++;
        end
        n_cmp++;
        if (k != 2 * DIV - 2) begin
            n_bad++;
            $display("FAIL bp_accept_cycle got %0d want %0d", k, 2 * DIV - 2);
        end
        step(1);
        audio_in_stb = 1'b0;
        n_cmp++;
        if (frame_stb_out !== 1'b1 || underrun_out !== 1'b0 ||
            audio_in_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_load got stb=%b und=%b ack=%b want 1 0 0",
                     frame_stb_out, underrun_out, audio_in_ack);
        end
        collect(w, oth, lre, ok);
        n_cmp++;
        if (!ok || w !== 32'h1111_2222 || oth != 0) begin
            n_bad++;
            $display("FAIL bp_frame1 got %h oth=%0d want 11112222 0", w, oth);
        end
        wait_frame(ok, und);
        collect(w, oth, lre, ok);
        n_cmp++;
        if (und !== 1'b0 || w !== 32'h3333_4444 || oth != 0) begin
            n_bad++;
            $display("FAIL bp_frame2 got %h und=%0d want 33334444 0", w, und);
        end
        wait_frame(ok, und);
        collect(w, oth, lre, ok);
        n_cmp++;
        if (und !== 1'b1 || w !== 32'd0) begin
            n_bad++;
            $display("FAIL bp_no_dup got %h und=%0d want 0 1", w, und);
        end
    endtask

    task automatic test_underrun;
        logic [31:0] w;
        int oth, lre;
        bit ok, und;
        do_reset();
        audio_in = 32'h7FFF_8001;
        audio_in_stb = 1'b1;
        step(1);
        audio_in_stb = 1'b0;
        wait_frame(ok, und);
        collect(w, oth, lre, ok);
        n_cmp++;
        if (w !== 32'h7FFF_8001) begin
            n_bad++;
            $display("FAIL ur_first got %h want 7fff8001", w);
        end
        wait_frame(ok, und);
        n_cmp++;
        if (!ok || und !== 1'b1) begin
            n_bad++;
            $display("FAIL ur_pulse got ok=%0d und=%0d want 1 1", ok, und);
        end
        step(1);
        n_cmp++;
        if (underrun_out !== 1'b0) begin
            n_bad++;
            $display("FAIL ur_width got %b want 0", underrun_out);
        end
        collect(w, oth, lre, ok);
        n_cmp++;
        if (!ok || w !== 32'd0 || oth != 0 || lre != 0) begin
            n_bad++;
            $display("FAIL ur_frame got %h oth=%0d lr=%0d want 0 0 0",
                     w, oth, lre);
        end
    endtask

    task automatic test_simultaneous;
        logic [31:0] w;
        int oth, lre;
        bit ok, und;
        do_reset();
        audio_in = 32'hDEAD_BEEF;
        audio_in_stb = 1'b1;
        step(1);
        audio_in_stb = 1'b0;
        step(2 * DIV - 2);
        audio_in = 32'h0123_4567;
        audio_in_stb = 1'b1;
        n_cmp++;
        if (audio_in_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL sim_ack_at_load got %b want 1", audio_in_ack);
        end
        step(1);
        audio_in_stb = 1'b0;
        n_cmp++;
        if (frame_stb_out !== 1'b1 || underrun_out !== 1'b0 ||
            audio_in_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL sim_after got stb=%b und=%b ack=%b want 1 0 0",
                     frame_stb_out, underrun_out, audio_in_ack);
        end
        collect(w, oth, lre, ok);
        n_cmp++;
        if (w !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL sim_old got %h want deadbeef", w);
        end
        wait_frame(ok, und);
        collect(w, oth, lre, ok);
        n_cmp++;
        if (und !== 1'b0 || w !== 32'h0123_4567) begin
            n_bad++;
            $display("FAIL sim_new got %h und=%0d want 01234567 0", w, und);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] w;
        int oth, lre, c0;
        bit ok, und;
        do_reset();
        audio_in = 32'hCAFE_F00D;
        audio_in_stb = 1'b1;
        step(1);
        audio_in_stb = 1'b0;
        wait_frame(ok, und);
        audio_in = 32'hBAD0_BAD0;
        audio_in_stb = 1'b1;
        step(1);
        audio_in_stb = 1'b0;
        // Now 17 clks after release; slot 20 begins at clk 16 + 20*16.
        step(2 * DIV + 20 * 2 * DIV + 4 - 17);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bclk_out, lrclk_out, dout_out, audio_in_ack,
             frame_stb_out, underrun_out} !== 6'b010100) begin
            n_bad++;
            $display("FAIL mid_reset_vals got %b want 010100",
                     {bclk_out, lrclk_out, dout_out, audio_in_ack,
                      frame_stb_out, underrun_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        wait_frame(ok, und);
        n_cmp++;
        if (!ok || und !== 1'b1 || cyc - c0 != 2 * DIV) begin
            n_bad++;
            $display("FAIL mid_first got und=%0d at %0d want 1 at %0d",
                     und, cyc - c0, 2 * DIV);
        end
        collect(w, oth, lre, ok);
        wait_frame(ok, und);
        n_cmp++;
        if (w !== 32'd0 || und !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_discard got %h und2=%0d want 0 1", w, und);
        end
        collect(w, oth, lre, ok);
        n_cmp++;
        if (w !== 32'd0 || oth != 0) begin
            n_bad++;
            $display("FAIL mid_discard2 got %h want 0", w);
        end
    endtask

    // Random words with random gaps; each load takes the oldest word
    // transferred before it, or outputs a zero frame as an underrun.
    task automatic test_random;
        localparam int NW = 6;
        int popped;
        bit drv_to;
        popped = 0;
        drv_to = 1'b0;
        do_reset();
        fork
            begin
                for (int k = 0; k < NW; k++) begin
                    bit done;
                    step($urandom_range(0, 1500));
                    audio_in = $urandom;
                    audio_in_stb = 1'b1;
                    done = 1'b0;
                    for (int i = 0; i < 3000 && !done; i++) begin
                        if (audio_in_ack) begin
                            q.push_back('{w: audio_in, t: cyc + 1});
                            done = 1'b1;
                        end
                        step(1);
                    end
                    audio_in_stb = 1'b0;
                    if (!done) drv_to = 1'b1;
                end
            end
            begin
                logic [31:0] w, exp_w;
                int oth, lre;
                bit ok, und, exp_u;
                for (int f = 0; f < 40 && popped < NW; f++) begin
                    wait_frame(ok, und);
                    if (!ok) break;
                    if (q.size() > 0 && q[0].t < cyc) begin
                        exp_w = q.pop_front().w;
                        exp_u = 1'b0;
                        popped++;
                    end else begin
                        exp_w = 32'd0;
                        exp_u = 1'b1;
                    end
                    collect(w, oth, lre, ok);
                    n_cmp++;
                    if (!ok || w !== exp_w || und !== exp_u ||
                        oth != 0 || lre != 0) begin
                        n_bad++;
                        $display("FAIL rand_frame%0d got %h und=%0d want %h und=%0d",
                                 f, w, und, exp_w, exp_u);
                    end
                end
            end
        join
        n_cmp++;
        if (popped != NW || drv_to) begin
            n_bad++;
            $display("FAIL rand_count got %0d timeout=%0d want %0d 0",
                     popped, drv_to, NW);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
